switch_nport: RTL and testbench

SWITCH_NPORT -- requirements
Module: switch_nport

---
 rtl/switch_nport.sv | 149 ++++++++++++++
 tb/tb_switch_nport.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_nport.sv
// switch_nport: N-port one-beat packet switch; per-ingress FIFO, per-egress round-robin output register.
// Optional macro SWITCH_NPORT_DROP_CNT_EN enables the saturating drop counter (otherwise drop_cnt is 0).
module switch_nport #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             in_valid,
   output logic [NUM_PORTS-1:0]             in_ready,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  in_source,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  in_target,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
   output logic [NUM_PORTS-1:0]             out_valid,
   input  logic [NUM_PORTS-1:0]             out_ready,
   output logic [NUM_PORTS*ADDR_WIDTH-1:0]  out_source,
   output logic [NUM_PORTS*ADDR_WIDTH-1:0]  out_target,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
   output logic [15:0]                      drop_cnt
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int EW = 2*ADDR_WIDTH + DATA_WIDTH;

   logic [NUM_PORTS-1:0][FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
   logic [NUM_PORTS-1:0][FW:0]                   wp_q, wp_d, rp_q, rp_d;
   logic [NUM_PORTS-1:0][PW-1:0]                 rr_q, rr_d, gnt_idx;
   logic [NUM_PORTS-1:0][EW-1:0]                 head, out_ent_q, out_ent_d;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]         head_tgt;
   logic [NUM_PORTS-1:0] full, empty, wr_en, pop, gnt_vld, load_en;
   logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
   logic                 rdy_en_q, rdy_en_d;
   int                   arb_idx;

   // in_ready stays low until the first edge after reset release
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         full[i]     = (wp_q[i][FW] != rp_q[i][FW]) && (wp_q[i][FW-1:0] == rp_q[i][FW-1:0]);
         empty[i]    = (wp_q[i] == rp_q[i]);
         head[i]     = mem_q[i][rp_q[i][FW-1:0]];
         head_tgt[i] = head[i][DATA_WIDTH +: ADDR_WIDTH];
         in_ready[i] = rdy_en_q & ~full[i];
         wr_en[i]    = in_valid[i] & in_ready[i] &
                       (32'(in_target[i*ADDR_WIDTH +: ADDR_WIDTH]) < NUM_PORTS);
      end
   end

   always_comb begin
      gnt_vld = '0;
      gnt_idx = '0;
      load_en = '0;
      pop     = '0;
      arb_idx = 0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         load_en[j] = ~out_valid_q[j] | out_ready[j];
         for (int k = 0; k < NUM_PORTS; k++) begin
            arb_idx = (int'(rr_q[j]) + k) % NUM_PORTS;
            if (load_en[j] && !gnt_vld[j] && !empty[arb_idx] &&
                (32'(head_tgt[arb_idx]) == j)) begin
               gnt_vld[j] = 1'b1;
               gnt_idx[j] = PW'(arb_idx);
            end
         end
         if (gnt_vld[j]) pop[gnt_idx[j]] = 1'b1;
      end
   end

   always_comb begin
      mem_d       = mem_q;
      wp_d        = wp_q;
      rp_d        = rp_q;
      rr_d        = rr_q;
      out_valid_d = out_valid_q;
      out_ent_d   = out_ent_q;
      rdy_en_d    = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (wr_en[i]) begin
            mem_d[i][wp_q[i][FW-1:0]] = {in_source[i*ADDR_WIDTH +: ADDR_WIDTH],
                                         in_target[i*ADDR_WIDTH +: ADDR_WIDTH],
                                         in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            wp_d[i] = wp_q[i] + 1'b1;
         end
         if (pop[i]) rp_d[i] = rp_q[i] + 1'b1;
      end
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (load_en[j]) begin
            out_valid_d[j] = gnt_vld[j];
            if (gnt_vld[j]) begin
               out_ent_d[j] = head[gnt_idx[j]];
               rr_d[j]      = PW'((int'(gnt_idx[j]) + 1) % NUM_PORTS);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q       <= '0;
         wp_q        <= '0;
         rp_q        <= '0;
         rr_q        <= '0;
         out_valid_q <= '0;
         out_ent_q   <= '0;
         rdy_en_q    <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_ent_q   <= out_ent_d;
         rdy_en_q    <= rdy_en_d;
      end
   end

   assign out_valid = out_valid_q;
   for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
      assign out_source[j*ADDR_WIDTH +: ADDR_WIDTH] = out_ent_q[j][DATA_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];
      assign out_target[j*ADDR_WIDTH +: ADDR_WIDTH] = out_ent_q[j][DATA_WIDTH +: ADDR_WIDTH];
      assign out_data[j*DATA_WIDTH +: DATA_WIDTH]   = out_ent_q[j][DATA_WIDTH-1:0];
   end

`ifdef SWITCH_NPORT_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum = {1'b0, drop_cnt_q};
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (in_valid[i] && in_ready[i] &&
             (32'(in_target[i*ADDR_WIDTH +: ADDR_WIDTH]) >= NUM_PORTS))
            drop_sum = drop_sum + 17'd1;
      end
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_cnt_q <= '0;
      else     drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_nport.sv
// Directed bench for switch_nport: scoreboard queues per egress, checked by an independent monitor.
module tb_switch_nport;
   localparam int NP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    in_valid, in_ready, out_valid, out_ready;
   logic [15:0]   in_source, in_target, out_source, out_target;
   logic [63:0]   in_data, out_data;
   logic [15:0]   drop_cnt;

   logic [23:0]   expq [NP][$];
   int            vectors = 0;
   int            errs    = 0;

   switch_nport #(.NUM_PORTS(4), .DATA_WIDTH(16), .ADDR_WIDTH(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_source(in_source), .in_target(in_target), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_source(out_source), .out_target(out_target), .out_data(out_data),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: any egress transfer must match the head of that egress's expected queue
   always @(negedge clk) begin
      if (!rst) begin
         for (int j = 0; j < NP; j++) begin
            if (out_valid[j] && out_ready[j]) begin
               logic [23:0] got, exp;
               got = {out_source[j*4 +: 4], out_target[j*4 +: 4], out_data[j*16 +: 16]};
               vectors++;
               if (expq[j].size() == 0) begin
                  errs++;
                  $display("FAIL egress%0d unexpected beat: got %h, expected none", j, got);
               end else begin
                  exp = expq[j].pop_front();
                  if (got !== exp) begin
                     errs++;
                     $display("FAIL egress%0d beat: got %h, expected %h", j, got, exp);
                  end
               end
            end
         end
      end
   end

   task automatic drive(input int p, input logic [3:0] tgt, input logic [15:0] dat);
      in_valid[p]          = 1'b1;
      in_source[p*4 +: 4]  = 4'(p);
      in_target[p*4 +: 4]  = tgt;
      in_data[p*16 +: 16]  = dat;
   endtask

   task automatic send(input int p, input logic [3:0] tgt, input logic [15:0] dat, input bit expect_out);
      int budget;
      budget = 0;
      drive(p, tgt, dat);
      while (!in_ready[p] && budget < 50) begin
         tick();
         budget++;
      end
      if (!in_ready[p]) begin
         vectors++;
         errs++;
         $display("FAIL send_timeout port%0d: in_ready 0, expected 1", p);
      end else begin
         if (expect_out) expq[tgt[1:0]].push_back({4'(p), tgt, dat});
         tick();
      end
      in_valid[p] = 1'b0;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 0;
      while ((expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0 && budget < 200) begin
         tick();
         budget++;
      end
      check(name, 32'(expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_drop;
      rst = 1'b1;
      in_valid = '0; in_source = '0; in_target = '0; in_data = '0;
      out_ready = 4'hF;
      tick(); tick();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_data", out_data[31:0] | out_data[63:32], 32'h0);
      check("rst_out_src_tgt", {out_source, out_target}, 32'h0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
      rst = 1'b0;
      #1;
      check("release_in_ready_before_edge", 32'(in_ready), 32'h0);
      tick();
      check("release_in_ready_after_edge", 32'(in_ready), 32'hF);

      // Latency: accepted at one edge, visible after the next
      drive(0, 4'd2, 16'hA5A5);
      expq[2].push_back({4'd0, 4'd2, 16'hA5A5});
      tick();
      in_valid = '0;
      check("lat_no_bypass", 32'(out_valid), 32'h0);
      tick();
      check("lat_out_valid", 32'(out_valid), 32'h4);
      check("lat_out_data", 32'(out_data[47:32]), 32'hA5A5);
      check("lat_out_source", 32'(out_source[11:8]), 32'h0);
      drain("lat_drain");

      // All four ingresses to egress 1: round-robin sources at one beat per cycle
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < NP; p++)
            expq[1].push_back({4'(p), 4'd1, 16'h2800 + 16'(r*16 + p)});
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NP; p++) drive(p, 4'd1, 16'h2800 + 16'(r*16 + p));
         check("rr_in_ready", 32'(in_ready), 32'hF);
         tick();
      end
      in_valid = '0;
      for (int k = 0; k < 8; k++) begin
         check("rr_throughput", 32'(out_valid[1]), 32'h1);
         tick();
      end
      drain("rr_drain");

      // Backpressure on egress 3: egress register + 4 FIFO entries, then ingress stalls
      out_ready = 4'b0111;
      for (int n = 0; n < 5; n++) send(0, 4'd3, 16'h3000 + 16'(n), 1'b1);
      check("bp_in_ready_full", 32'(in_ready[0]), 32'h0);
      for (int k = 0; k < 3; k++) begin
         check("bp_hold_valid", 32'(out_valid[3]), 32'h1);
         check("bp_hold_data", 32'(out_data[63:48]), 32'h3000);
         tick();
      end
      out_ready = 4'hF;
      drain("bp_drain");
      check("bp_in_ready_recovered", 32'(in_ready[0]), 32'h1);

      // Out-of-range target is accepted and discarded
      for (int n = 0; n < 3; n++) send(1, 4'd7, 16'h7700 + 16'(n), 1'b0);
      tick(); tick(); tick();
`ifdef SWITCH_NPORT_DROP_CNT_EN
      exp_drop = 16'd3;
`else
      exp_drop = 16'd0;
`endif
      check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      check("drop_no_out", 32'(out_valid), 32'h0);

      // Reset mid-traffic: egress 0 holding a beat, three more queued in FIFO 2
      out_ready = 4'b1110;
      for (int n = 0; n < 4; n++) send(2, 4'd0, 16'h5000 + 16'(n), 1'b0);
      check("pre_rst_valid", 32'(out_valid[0]), 32'h1);
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'h0);
      check("async_rst_in_ready", 32'(in_ready), 32'h0);
      for (int j = 0; j < NP; j++) expq[j].delete();
      tick();
      rst = 1'b0;
      out_ready = 4'hF;
      for (int k = 0; k < 8; k++) tick();
      check("post_rst_no_stale", 32'(out_valid), 32'h0);
      // rr[0] back at 0: ingress 1 must win over ingress 3
      drive(1, 4'd0, 16'h6001);
      drive(3, 4'd0, 16'h6003);
      expq[0].push_back({4'd1, 4'd0, 16'h6001});
      expq[0].push_back({4'd3, 4'd0, 16'h6003});
      tick();
      in_valid = '0;
      tick();
      check("post_rst_rr_first", 32'(out_source[3:0]), 32'h1);
      drain("post_rst_drain");

      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
